// File: rtl/pipe_pkg.sv
// Shared types for the MEM->WB elastic stage: occupancy states and the
// default-width writeback bundle layout.
package pipe_pkg;

    localparam int PIPE_XLEN = 64;
    localparam int PIPE_REGW = 5;

    // Encoding doubles as the bundle count reported on the occupancy port.
    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_TWO   = 2'd2
    } stage_occ_e;

    // Field order matches the parametrised bundle used inside the stage.
    typedef struct packed {
        logic [PIPE_XLEN-1:0] read_data;
        logic [PIPE_XLEN-1:0] alu_result;
        logic [PIPE_REGW-1:0] rd;
        logic                 memtoreg;
        logic                 regwrite;
    } mem_wb_bundle_t;

endpackage

// File: rtl/pipe_entry_reg.sv
// One bundle register: synchronous clear, load enable, payload copied verbatim.
module pipe_entry_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] entry_q;
    logic [W-1:0] entry_d;

    // Hold unless a new bundle is written into this slot.
    always_comb begin
        entry_d = entry_q;
        if (load) begin
            entry_d = d;
        end
    end

    // Payload register with synchronous clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            entry_q <= '0;
        end else begin
            entry_q <= entry_d;
        end
    end

    assign q = entry_q;

endmodule

// File: rtl/mem_wb_stage_elastic.sv
// MEM->WB pipeline stage with valid/ready handshake, optional one-entry skid
// slot, flush, x0 write guard and pre-muxed writeback data.
module mem_wb_stage_elastic
    import pipe_pkg::*;
#(
    parameter int XLEN    = 64,
    parameter int REGW    = 5,
    parameter int SKID_EN = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_read_data,
    input  logic [XLEN-1:0] in_alu_result,
    input  logic [REGW-1:0] in_rd,
    input  logic            in_memtoreg,
    input  logic            in_regwrite,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_read_data,
    output logic [XLEN-1:0] out_alu_result,
    output logic [REGW-1:0] out_rd,
    output logic            out_memtoreg,
    output logic            out_regwrite,
    output logic [XLEN-1:0] wb_data,
    output logic [1:0]      occupancy
);

    localparam int PW = 2*XLEN + REGW + 2;

    typedef struct packed {
        logic [XLEN-1:0] read_data;
        logic [XLEN-1:0] alu_result;
        logic [REGW-1:0] rd;
        logic            memtoreg;
        logic            regwrite;
    } bundle_t;

    stage_occ_e occ_q, occ_d;
    bundle_t    in_b, head_q, skid_q, head_d;
    logic       head_load, skid_load, head_from_skid;
    logic       acc, pop;

    assign in_b = '{read_data:  in_read_data,
                    alu_result: in_alu_result,
                    rd:         in_rd,
                    memtoreg:   in_memtoreg,
                    regwrite:   in_regwrite};

    assign out_valid = (occ_q != OCC_EMPTY);
    assign acc       = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // Occupancy transitions and slot load enables; flush overrides everything.
    always_comb begin
        occ_d          = occ_q;
        head_load      = 1'b0;
        skid_load      = 1'b0;
        head_from_skid = 1'b0;
        unique case (occ_q)
            OCC_EMPTY: begin
                if (acc) begin
                    head_load = 1'b1;
                    occ_d     = OCC_ONE;
                end
            end
            OCC_ONE: begin
                if (acc && pop) begin
                    head_load = 1'b1;
                end else if (acc && (SKID_EN != 0)) begin
                    skid_load = 1'b1;
                    occ_d     = OCC_TWO;
                end else if (pop) begin
                    occ_d = OCC_EMPTY;
                end
            end
            OCC_TWO: begin
                if (pop) begin
                    head_load      = 1'b1;
                    head_from_skid = 1'b1;
                    occ_d          = OCC_ONE;
                end
            end
            default: occ_d = OCC_EMPTY;
        endcase
        if (flush) begin
            occ_d     = OCC_EMPTY;
            head_load = 1'b0;
            skid_load = 1'b0;
        end
        head_d = head_from_skid ? skid_q : in_b;
    end

    // Occupancy state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            occ_q <= OCC_EMPTY;
        end else begin
            occ_q <= occ_d;
        end
    end

    pipe_entry_reg #(.W(PW)) u_head (
        .clk   (clk),
        .reset (reset),
        .load  (head_load),
        .d     (head_d),
        .q     (head_q)
    );

    generate
        if (SKID_EN != 0) begin : g_skid
            logic in_ready_q, in_ready_d;

            // Ready is a registered look-ahead of next occupancy, decoupling it from out_ready.
            always_comb begin
                in_ready_d = (occ_d != OCC_TWO);
            end

            // Registered upstream ready.
            always_ff @(posedge clk) begin
                if (reset) begin
                    in_ready_q <= 1'b1;
                end else begin
                    in_ready_q <= in_ready_d;
                end
            end

            assign in_ready = in_ready_q;

            pipe_entry_reg #(.W(PW)) u_skid (
                .clk   (clk),
                .reset (reset),
                .load  (skid_load),
                .d     (in_b),
                .q     (skid_q)
            );
        end else begin : g_noskid
            logic unused_skid_load;
            assign unused_skid_load = skid_load;
            assign skid_q           = '0;
            assign in_ready         = !out_valid || out_ready;
        end
    endgenerate

    assign out_read_data  = head_q.read_data;
    assign out_alu_result = head_q.alu_result;
    assign out_rd         = head_q.rd;
    assign out_memtoreg   = head_q.memtoreg;
    assign out_regwrite   = out_valid && head_q.regwrite && (head_q.rd != '0);
    assign wb_data        = head_q.memtoreg ? head_q.read_data : head_q.alu_result;
    assign occupancy      = occ_q;

endmodule

// File: tb/tb_mem_wb_stage_elastic.sv
// Bench for mem_wb_stage_elastic: skid and single-entry builds driven by the
// same stimulus, each compared against a queue model of the stage.
module tb_mem_wb_stage_elastic;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, flush, in_valid, in_memtoreg, in_regwrite, out_ready;
    logic [63:0] in_read_data, in_alu_result;
    logic [4:0]  in_rd;

    logic        in_ready, out_valid, out_memtoreg, out_regwrite;
    logic [63:0] out_read_data, out_alu_result, wb_data;
    logic [4:0]  out_rd;
    logic [1:0]  occupancy;

    logic        d0_in_ready, d0_out_valid, d0_out_memtoreg, d0_out_regwrite;
    logic [63:0] d0_out_read_data, d0_out_alu_result, d0_wb_data;
    logic [4:0]  d0_out_rd;
    logic [1:0]  d0_occupancy;

    mem_wb_stage_elastic #(.XLEN(64), .REGW(5), .SKID_EN(1)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_read_data(in_read_data), .in_alu_result(in_alu_result),
        .in_rd(in_rd), .in_memtoreg(in_memtoreg), .in_regwrite(in_regwrite),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_read_data(out_read_data), .out_alu_result(out_alu_result),
        .out_rd(out_rd), .out_memtoreg(out_memtoreg), .out_regwrite(out_regwrite),
        .wb_data(wb_data), .occupancy(occupancy)
    );

    mem_wb_stage_elastic #(.XLEN(64), .REGW(5), .SKID_EN(0)) dut0 (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(d0_in_ready),
        .in_read_data(in_read_data), .in_alu_result(in_alu_result),
        .in_rd(in_rd), .in_memtoreg(in_memtoreg), .in_regwrite(in_regwrite),
        .out_valid(d0_out_valid), .out_ready(out_ready),
        .out_read_data(d0_out_read_data), .out_alu_result(d0_out_alu_result),
        .out_rd(d0_out_rd), .out_memtoreg(d0_out_memtoreg), .out_regwrite(d0_out_regwrite),
        .wb_data(d0_wb_data), .occupancy(d0_occupancy)
    );

    typedef struct {
        logic [63:0] rdat;
        logic [63:0] alu;
        logic [4:0]  rd;
        logic        m2r;
        logic        rw;
    } bnd_t;

    bnd_t q1[$];
    bnd_t q0[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Compare one DUT's visible state with the model's queue contents.
    task automatic check_side(input string p, input int sz, input bnd_t h, input logic exp_rdy,
                              input logic a_rdy, input logic a_ov, input logic [63:0] a_rdat,
                              input logic [63:0] a_alu, input logic [4:0] a_rd, input logic a_m2r,
                              input logic a_rw, input logic [63:0] a_wb, input logic [1:0] a_occ);
        check_eq({p, ".in_ready"}, {63'd0, a_rdy}, {63'd0, exp_rdy});
        check_eq({p, ".out_valid"}, {63'd0, a_ov}, {63'd0, sz > 0});
        check_eq({p, ".occupancy"}, {62'd0, a_occ}, 64'(sz));
        check_eq({p, ".out_regwrite"}, {63'd0, a_rw}, {63'd0, (sz > 0) && h.rw && (h.rd != 5'd0)});
        if (sz > 0) begin
            check_eq({p, ".read_data"}, a_rdat, h.rdat);
            check_eq({p, ".alu_result"}, a_alu, h.alu);
            check_eq({p, ".rd"}, {59'd0, a_rd}, {59'd0, h.rd});
            check_eq({p, ".memtoreg"}, {63'd0, a_m2r}, {63'd0, h.m2r});
            check_eq({p, ".wb_data"}, a_wb, h.m2r ? h.rdat : h.alu);
        end
    endtask

    // One clock: apply inputs at the falling edge, check, advance the models.
    task automatic step(input logic rst_i, input logic fl_i, input logic iv,
                        input logic [63:0] rdat, input logic [63:0] alu, input logic [4:0] rd,
                        input logic m2r, input logic rw, input logic ordy);
        bnd_t nb, h1, h0;
        logic r1, r0, a1, a0, p1, p0;
        reset = rst_i; flush = fl_i; in_valid = iv;
        in_read_data = rdat; in_alu_result = alu; in_rd = rd;
        in_memtoreg = m2r; in_regwrite = rw; out_ready = ordy;
        #1;
        h1 = '{default: 0};
        h0 = '{default: 0};
        if (q1.size() > 0) h1 = q1[0];
        if (q0.size() > 0) h0 = q0[0];
        r1 = (q1.size() != 2);
        r0 = (q0.size() == 0) || ordy;
        check_side("skid", q1.size(), h1, r1, in_ready, out_valid, out_read_data,
                   out_alu_result, out_rd, out_memtoreg, out_regwrite, wb_data, occupancy);
        check_side("noskid", q0.size(), h0, r0, d0_in_ready, d0_out_valid, d0_out_read_data,
                   d0_out_alu_result, d0_out_rd, d0_out_memtoreg, d0_out_regwrite, d0_wb_data,
                   d0_occupancy);
        nb = '{rdat: rdat, alu: alu, rd: rd, m2r: m2r, rw: rw};
        a1 = iv && r1;  p1 = (q1.size() > 0) && ordy;
        a0 = iv && r0;  p0 = (q0.size() > 0) && ordy;
        if (rst_i || fl_i) begin
            q1.delete();
            q0.delete();
        end else begin
            if (p1) void'(q1.pop_front());
            if (a1) q1.push_back(nb);
            if (p0) void'(q0.pop_front());
            if (a0) q0.push_back(nb);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input logic ordy);
        step(1'b0, 1'b0, 1'b0, 64'd0, 64'd0, 5'd0, 1'b0, 1'b0, ordy);
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_read_data = '0; in_alu_result = '0; in_rd = '0;
        in_memtoreg = 1'b0; in_regwrite = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);

        // Reset while two bundles are held.
        step(0, 0, 1, 64'h11, 64'h12, 5'd3, 0, 1, 0);
        step(0, 0, 1, 64'h21, 64'h22, 5'd4, 1, 1, 0);
        check_eq("t1.occ_before", {62'd0, occupancy}, 64'd2);
        step(1, 0, 1, 64'h31, 64'h32, 5'd7, 1, 1, 0);
        check_eq("t1.occ", {62'd0, occupancy}, 64'd0);
        check_eq("t1.out_valid", {63'd0, out_valid}, 64'd0);
        check_eq("t1.read_data", out_read_data, 64'd0);
        check_eq("t1.alu_result", out_alu_result, 64'd0);
        check_eq("t1.rd", {59'd0, out_rd}, 64'd0);
        check_eq("t1.memtoreg", {63'd0, out_memtoreg}, 64'd0);
        check_eq("t1.regwrite", {63'd0, out_regwrite}, 64'd0);
        check_eq("t1.wb_data", wb_data, 64'd0);
        check_eq("t1.in_ready", {63'd0, in_ready}, 64'd1);

        // Back-to-back streaming with out_ready high.
        step(0, 0, 1, 64'd0, 64'h10, 5'd1, 0, 1, 1);
        check_eq("t2.wb0", wb_data, 64'h10);
        step(0, 0, 1, 64'd0, 64'h20, 5'd1, 0, 1, 1);
        check_eq("t2.wb1", wb_data, 64'h20);
        check_eq("t2.valid1", {63'd0, out_valid}, 64'd1);
        step(0, 0, 1, 64'd0, 64'h30, 5'd1, 0, 1, 1);
        check_eq("t2.wb2", wb_data, 64'h30);
        idle(1);

        // Stall with two held, then release in order.
        step(0, 0, 1, 64'd0, 64'hA, 5'd5, 0, 1, 0);
        step(0, 0, 1, 64'd0, 64'hB, 5'd6, 0, 1, 0);
        check_eq("t3.occ", {62'd0, occupancy}, 64'd2);
        check_eq("t3.in_ready", {63'd0, in_ready}, 64'd0);
        check_eq("t3.head", {59'd0, out_rd}, 64'd5);
        idle(0);
        check_eq("t3.head_stable", {59'd0, out_rd}, 64'd5);
        idle(1);
        check_eq("t3.second", {59'd0, out_rd}, 64'd6);
        check_eq("t3.second_wb", wb_data, 64'hB);
        idle(1);
        check_eq("t3.drained", {63'd0, out_valid}, 64'd0);

        // Flush while full with an incoming bundle.
        step(0, 0, 1, 64'd0, 64'h55, 5'd8, 0, 1, 0);
        step(0, 0, 1, 64'd0, 64'h66, 5'd9, 0, 1, 0);
        step(0, 1, 1, 64'd0, 64'h777, 5'd7, 0, 1, 0);
        check_eq("t4.occ", {62'd0, occupancy}, 64'd0);
        check_eq("t4.out_valid", {63'd0, out_valid}, 64'd0);
        check_eq("t4.regwrite", {63'd0, out_regwrite}, 64'd0);
        for (int i = 0; i < 3; i++) begin
            idle(1);
            check_eq("t4.no_ghost", {63'd0, out_valid}, 64'd0);
        end

        // Load-data select and x0 guard.
        step(0, 0, 1, 64'hDEAD, 64'hBEEF, 5'd0, 1, 1, 1);
        check_eq("t5.wb_data", wb_data, 64'hDEAD);
        check_eq("t5.out_valid", {63'd0, out_valid}, 64'd1);
        check_eq("t5.x0_regwrite", {63'd0, out_regwrite}, 64'd0);
        idle(1);

        // Single-entry build: ready follows out_ready combinationally.
        step(0, 0, 1, 64'd0, 64'h99, 5'd3, 0, 1, 0);
        check_eq("t6.head_valid", {63'd0, d0_out_valid}, 64'd1);
        check_eq("t6.rdy_stalled", {63'd0, d0_in_ready}, 64'd0);
        out_ready = 1'b1;
        #1;
        check_eq("t6.rdy_released", {63'd0, d0_in_ready}, 64'd1);
        idle(1);
        idle(1);

        // Randomised traffic with occasional flush and reset.
        for (int i = 0; i < 400; i++) begin
            logic [4:0] rrd;
            rrd = 5'($urandom_range(0, 31));
            if ($urandom_range(0, 3) == 0) rrd = 5'd0;
            step($urandom_range(0, 63) == 0, $urandom_range(0, 15) == 0,
                 $urandom_range(0, 3) != 0, {$urandom, $urandom}, {$urandom, $urandom},
                 rrd, 1'($urandom), 1'($urandom), $urandom_range(0, 2) != 0);
        end
        idle(1);
        idle(1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
